// File: rtl/chess_pkg.sv
// Board scan shared types: FSM state, board geometry defaults and
// square-index to row/column helpers.
package chess_pkg;

  localparam int CHESS_SQUARES_DEF = 64;
  localparam int SQUARE_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } scan_state_e;

  function automatic logic [2:0] idx_row(input logic [5:0] idx);
    return idx[5:3];
  endfunction

  function automatic logic [2:0] idx_col(input logic [5:0] idx);
    return idx[2:0];
  endfunction

endpackage

// File: rtl/board_square_mux.sv
// Selects one square from the snapshot board and flags it as skippable when
// it matches the previous frame (only meaningful while prev_valid is set).
module board_square_mux
  import chess_pkg::*;
#(
  parameter int CHESS_SQUARES = CHESS_SQUARES_DEF,
  parameter int SQUARE_WIDTH  = SQUARE_WIDTH_DEF,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input  logic [MATRIX_WIDTH-1:0] snap,
  input  logic [MATRIX_WIDTH-1:0] prev,
  input  logic                    prev_valid,
  input  logic [5:0]              sel,
  output logic [SQUARE_WIDTH-1:0] piece,
  output logic                    skip
);

  logic [SQUARE_WIDTH-1:0] cur_sq [CHESS_SQUARES];
  logic [SQUARE_WIDTH-1:0] prv_sq [CHESS_SQUARES];

  for (genvar i = 0; i < CHESS_SQUARES; i++) begin : g_sq
    assign cur_sq[i] = snap[i*SQUARE_WIDTH +: SQUARE_WIDTH];
    assign prv_sq[i] = prev[i*SQUARE_WIDTH +: SQUARE_WIDTH];
  end

  assign piece = cur_sq[sel];
  assign skip  = prev_valid && (cur_sq[sel] == prv_sq[sel]);

endmodule

// File: rtl/board_scan_streamer.sv
// Streams a snapshot of the board one square record per transfer, index 0..63.
// Optional BOARD_SCAN_DIFF_ONLY_EN: skip squares unchanged since the last full scan.
module board_scan_streamer
  import chess_pkg::*;
#(
  parameter int CHESS_SQUARES = CHESS_SQUARES_DEF,
  parameter int SQUARE_WIDTH  = SQUARE_WIDTH_DEF,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Matrix,
  input  logic                    start,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [5:0]              out_index,
  output logic [2:0]              out_row,
  output logic [2:0]              out_col,
  output logic [SQUARE_WIDTH-1:0] out_piece,
  output logic                    busy,
  output logic                    done
);

  localparam logic [5:0] LAST_IDX = 6'(CHESS_SQUARES - 1);

  scan_state_e             state_q, state_d;
  logic [5:0]              ptr_q, ptr_d;
  logic [MATRIX_WIDTH-1:0] snap_q, snap_d;
  logic [MATRIX_WIDTH-1:0] prev_frame;
  logic                    prev_ok;
  logic                    skip;

`ifdef BOARD_SCAN_DIFF_ONLY_EN
  logic [MATRIX_WIDTH-1:0] prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  assign prev_frame = prev_q;
  assign prev_ok    = prev_valid_q;
`else
  assign prev_frame = '0;
  assign prev_ok    = 1'b0;
`endif

  board_square_mux #(
    .CHESS_SQUARES (CHESS_SQUARES),
    .SQUARE_WIDTH  (SQUARE_WIDTH),
    .MATRIX_WIDTH  (MATRIX_WIDTH)
  ) u_mux (
    .snap       (snap_q),
    .prev       (prev_frame),
    .prev_valid (prev_ok),
    .sel        (ptr_q),
    .piece      (out_piece),
    .skip       (skip)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    snap_d    = snap_q;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
`ifdef BOARD_SCAN_DIFF_ONLY_EN
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = Matrix;
          ptr_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = !skip;
        // A skipped square advances exactly like a transferred one.
        if (skip || out_ready) begin
          if (ptr_q == LAST_IDX) state_d = ST_FINISH;
          else                   ptr_d   = ptr_q + 6'd1;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
`ifdef BOARD_SCAN_DIFF_ONLY_EN
        prev_d       = snap_q;
        prev_valid_d = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_index = ptr_q;
  assign out_row   = idx_row(ptr_q);
  assign out_col   = idx_col(ptr_q);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
    end
  end

`ifdef BOARD_SCAN_DIFF_ONLY_EN
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_board_scan_streamer.sv
// Directed bench for board_scan_streamer: full scan, ready backpressure,
// mid-scan board change, reset abort, and diff-only scans when enabled.
module tb_board_scan_streamer;

  localparam int SQ = 64;
  localparam int SW = 4;
  localparam int MW = SQ * SW;

  logic          clock = 1'b0;
  logic          resetApp;
  logic [MW-1:0] Matrix;
  logic          start;
  logic          out_ready;
  logic          out_valid;
  logic [5:0]    out_index;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic [SW-1:0] out_piece;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] q_idx [$];
  logic [2:0] q_row [$];
  logic [2:0] q_col [$];
  logic [3:0] q_pc  [$];

  board_scan_streamer #(.CHESS_SQUARES(SQ), .SQUARE_WIDTH(SW), .MATRIX_WIDTH(MW)) dut (
    .clock     (clock),
    .resetApp  (resetApp),
    .Matrix    (Matrix),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_piece (out_piece),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference board: square k holds (5k+10) mod 16, so square0=A, square63=5.
  function automatic logic [3:0] ref_pc(input int k);
    return 4'((k * 5 + 10) % 16);
  endfunction

  task automatic load_board();
    for (int k = 0; k < SQ; k++) Matrix[k*SW +: SW] = ref_pc(k);
  endtask

  // Cycle 0 is the start-acceptance cycle; done_cyc is the cycle done is seen.
  task automatic run_scan(input bit toggle, input int poke_cyc, input bit start_at_done,
                          output int done_cyc, output int n_done);
    logic       pv, pr;
    logic [5:0] pi;
    logic [3:0] pp;
    q_idx.delete(); q_row.delete(); q_col.delete(); q_pc.delete();
    done_cyc = -1;
    n_done   = 0;
    pv = 1'b0; pr = 1'b1; pi = '0; pp = '0;
    @(negedge clock);
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clock);
      start = (poke_cyc > 0 && c >= poke_cyc && c < poke_cyc + 3);
      if (c == poke_cyc) Matrix[10*SW +: SW] = 4'h7;
      out_ready = toggle ? c[0] : 1'b1;
      #1;
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_index", {26'd0, out_index}, {26'd0, pi});
        chk("hold_piece", {28'd0, out_piece}, {28'd0, pp});
      end
      if (out_valid && out_ready) begin
        q_idx.push_back(out_index);
        q_row.push_back(out_row);
        q_col.push_back(out_col);
        q_pc.push_back(out_piece);
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          chk("finish_valid", {31'd0, out_valid}, 32'd0);
          if (start_at_done) start = 1'b1;
        end
      end
      pv = out_valid; pr = out_ready; pi = out_index; pp = out_piece;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_full(input string tag);
    chk({tag, "_count"}, q_idx.size(), 32'd64);
    for (int k = 0; k < q_idx.size() && k < SQ; k++) begin
      chk({tag, "_idx"}, {26'd0, q_idx[k]}, k);
      chk({tag, "_pc"}, {28'd0, q_pc[k]}, {28'd0, ref_pc(k)});
    end
  endtask

  initial begin
    int dc, nd;
    bit seen30, bad;
    resetApp  = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    Matrix    = '0;
    load_board();
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_index", {26'd0, out_index}, 32'd0);
    chk("rst_piece", {28'd0, out_piece}, 32'd0);
    @(negedge clock);
    resetApp = 1'b0;

    // Full scan, continuous ready; start held high in the done cycle is ignored.
    run_scan(1'b0, 0, 1'b1, dc, nd);
    chk_full("t1");
    chk("t1_first_pc", {28'd0, q_pc[0]}, 32'hA);
    chk("t1_last_row", {29'd0, q_row[63]}, 32'd7);
    chk("t1_last_col", {29'd0, q_col[63]}, 32'd7);
    chk("t1_last_pc",  {28'd0, q_pc[63]}, 32'h5);
    chk("t1_row10", {29'd0, q_row[10]}, 32'd1);
    chk("t1_col10", {29'd0, q_col[10]}, 32'd2);
    chk("t1_done_cyc", dc, 32'd65);
    chk("t1_done_cnt", nd, 32'd1);

    // Ready toggling every cycle.
    run_scan(1'b1, 0, 1'b0, dc, nd);
    chk_full("t2");
    chk("t2_done_cnt", nd, 32'd1);

    // Square 10 changes 3->7 mid-scan while start pulses arrive.
    Matrix[10*SW +: SW] = 4'h3;
    run_scan(1'b0, 5, 1'b0, dc, nd);
    chk("t3_count", q_idx.size(), 32'd64);
    chk("t3_idx10", {26'd0, q_idx[10]}, 32'd10);
    chk("t3_pc10",  {28'd0, q_pc[10]}, 32'h3);
    chk("t3_idx63", {26'd0, q_idx[63]}, 32'd63);
    chk("t3_done_cyc", dc, 32'd65);
    chk("t3_done_cnt", nd, 32'd1);
    load_board();

    // Reset while index 30 is presented.
    @(negedge clock);
    start = 1'b1;
    out_ready = 1'b1;
    seen30 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      if (out_valid && out_index == 6'd30) begin
        seen30 = 1'b1;
        break;
      end
    end
    chk("t4_reach30", {31'd0, seen30}, 32'd1);
    resetApp = 1'b1;
    #1;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_index", {26'd0, out_index}, 32'd0);
    chk("t4_row",   {29'd0, out_row}, 32'd0);
    chk("t4_col",   {29'd0, out_col}, 32'd0);
    chk("t4_piece", {28'd0, out_piece}, 32'd0);
    chk("t4_busy",  {31'd0, busy}, 32'd0);
    chk("t4_done",  {31'd0, done}, 32'd0);
    @(negedge clock);
    resetApp = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      #1;
      if (out_valid || done || busy) bad = 1'b1;
    end
    chk("t4_quiet", {31'd0, bad}, 32'd0);
    run_scan(1'b0, 0, 1'b0, dc, nd);
    chk("t4_restart_idx", {26'd0, q_idx[0]}, 32'd0);
    chk_full("t4r");
    chk("t4_done_cyc", dc, 32'd65);

`ifdef BOARD_SCAN_DIFF_ONLY_EN
    @(negedge clock);
    resetApp = 1'b1;
    @(negedge clock);
    resetApp = 1'b0;
    Matrix[12*SW +: SW] = 4'h2;
    run_scan(1'b0, 0, 1'b0, dc, nd);
    chk("d1_count", q_idx.size(), 32'd64);
    chk("d1_done_cyc", dc, 32'd65);
    Matrix[12*SW +: SW] = 4'h9;
    run_scan(1'b0, 0, 1'b0, dc, nd);
    chk("d2_count", q_idx.size(), 32'd1);
    if (q_idx.size() > 0) begin
      chk("d2_idx", {26'd0, q_idx[0]}, 32'd12);
      chk("d2_row", {29'd0, q_row[0]}, 32'd1);
      chk("d2_col", {29'd0, q_col[0]}, 32'd4);
      chk("d2_pc",  {28'd0, q_pc[0]}, 32'h9);
    end
    chk("d2_done_cyc", dc, 32'd65);
    run_scan(1'b0, 0, 1'b0, dc, nd);
    chk("d3_count", q_idx.size(), 32'd0);
    chk("d3_done_cyc", dc, 32'd65);
    chk("d3_done_cnt", nd, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
